// File: rtl/mem_stage_if.sv
// Bus between the EX/MEM pipeline register and the lapido memory-access stage.
// There is no valid/ready pair: the stage accepts one instruction every cycle with no
// backpressure, and stalls are resolved upstream by the hazard unit.
interface mem_stage_if #(
  parameter int GPR_WIDTH      = 32,
  parameter int PC_WIDTH       = 16,
  parameter int GRP_ADDR_WIDTH = 4
);
  logic                      mem_write_enable;
  logic                      sel_beq_bne;
  logic                      sel_jt_jf;
  logic                      is_branch;
  logic                      sel_jflag_branch;
  logic [2:0]                cond_sel;
  logic [1:0]                wb_res_mux;
  logic                      reg_write_enable;
  logic [GPR_WIDTH-1:0]      imm;
  logic [PC_WIDTH-1:0]       next_pc;
  logic [PC_WIDTH-1:0]       branch_addr;
  logic [GPR_WIDTH-1:0]      alu_res;
  logic [GPR_WIDTH-1:0]      mem_addr;
  logic [GPR_WIDTH-1:0]      mem_data;
  logic [5:0]                flags;
  logic [GRP_ADDR_WIDTH-1:0] reg_dest;
  logic                      branch_taken;
  logic [PC_WIDTH-1:0]       out_branch_addr;
  logic [GPR_WIDTH-1:0]      EX_MEM_data;
  logic [GPR_WIDTH-1:0]      MEM_WB_data;
  logic [GRP_ADDR_WIDTH-1:0] out_reg_dest;
  logic                      out_reg_write_enable;

  modport master (
    output mem_write_enable, sel_beq_bne, sel_jt_jf, is_branch, sel_jflag_branch,
           cond_sel, wb_res_mux, reg_write_enable, imm, next_pc, branch_addr,
           alu_res, mem_addr, mem_data, flags, reg_dest,
    input  branch_taken, out_branch_addr, EX_MEM_data, MEM_WB_data,
           out_reg_dest, out_reg_write_enable
  );

  modport slave (
    input  mem_write_enable, sel_beq_bne, sel_jt_jf, is_branch, sel_jflag_branch,
           cond_sel, wb_res_mux, reg_write_enable, imm, next_pc, branch_addr,
           alu_res, mem_addr, mem_data, flags, reg_dest,
    output branch_taken, out_branch_addr, EX_MEM_data, MEM_WB_data,
           out_reg_dest, out_reg_write_enable
  );
endinterface

// File: rtl/mem_stage.sv
// lapido MEM stage: branch resolution, data memory, forwarding value and MEM/WB register.
// Define LAPIDO_MEM_STATS_EN to add the load/store/taken-branch counters.
module mem_stage #(
  parameter int DMEM_ADDR_BITS = 10,
  parameter int GPR_WIDTH      = 32,
  parameter int PC_WIDTH       = 16,
  parameter int GRP_ADDR_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
`ifdef LAPIDO_MEM_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_branches_taken
`endif
);
  logic [GPR_WIDTH-1:0]      dmem [0:(2**DMEM_ADDR_BITS)-1];
  logic [DMEM_ADDR_BITS-1:0] dmem_idx;
  logic [GPR_WIDTH-1:0]      load_data;
  logic                      flag_bit;
  logic                      cond;
  logic [GPR_WIDTH-1:0]      fwd_data;
  logic [GPR_WIDTH-1:0]      wb_data;
  logic                      unused_addr_bits;

  // Addresses wrap: only the low bits index the array.
  assign dmem_idx         = bus.mem_addr[DMEM_ADDR_BITS-1:0];
  assign unused_addr_bits = ^bus.mem_addr[GPR_WIDTH-1:DMEM_ADDR_BITS];
  assign load_data        = dmem[dmem_idx];

  always_comb begin
    flag_bit = 1'b0;
    case (bus.cond_sel)
      3'd0: flag_bit = bus.flags[0];
      3'd1: flag_bit = bus.flags[1];
      3'd2: flag_bit = bus.flags[2];
      3'd3: flag_bit = bus.flags[3];
      3'd4: flag_bit = bus.flags[4];
      3'd5: flag_bit = bus.flags[5];
      default: flag_bit = 1'b0;
    endcase
  end

  assign cond = bus.sel_jflag_branch ? (flag_bit ^ bus.sel_jt_jf)
                                     : (bus.flags[0] ^ bus.sel_beq_bne);
  assign bus.branch_taken    = bus.is_branch & cond & ~rst;
  assign bus.out_branch_addr = bus.branch_addr;

  // Forwarding never offers load data; load-use is stalled upstream.
  always_comb begin
    fwd_data = bus.alu_res;
    wb_data  = bus.alu_res;
    case (bus.wb_res_mux)
      2'b00: begin fwd_data = bus.alu_res;              wb_data = bus.alu_res; end
      2'b01: begin fwd_data = bus.alu_res;              wb_data = load_data; end
      2'b10: begin fwd_data = bus.imm;                  wb_data = bus.imm; end
      default: begin
        fwd_data = GPR_WIDTH'(bus.next_pc);
        wb_data  = GPR_WIDTH'(bus.next_pc);
      end
    endcase
  end
  assign bus.EX_MEM_data = fwd_data;

  // Memory contents survive reset; only the write is suppressed.
  always_ff @(posedge clk) begin
    if (!rst && bus.mem_write_enable) dmem[dmem_idx] <= bus.mem_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.MEM_WB_data          <= '0;
      bus.out_reg_dest         <= '0;
      bus.out_reg_write_enable <= 1'b0;
    end else begin
      bus.MEM_WB_data          <= wb_data;
      bus.out_reg_dest         <= bus.reg_dest;
      bus.out_reg_write_enable <= bus.reg_write_enable;
    end
  end

`ifdef LAPIDO_MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads          <= '0;
      stat_stores         <= '0;
      stat_branches_taken <= '0;
    end else begin
      if (bus.reg_write_enable && bus.wb_res_mux == 2'b01) stat_loads <= stat_loads + 32'd1;
      if (bus.mem_write_enable) stat_stores <= stat_stores + 32'd1;
      if (bus.branch_taken) stat_branches_taken <= stat_branches_taken + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; stats checks are built only with LAPIDO_MEM_STATS_EN.
module tb_mem_stage;
  localparam int AB  = 10;
  localparam int GW  = 32;
  localparam int PW  = 16;
  localparam int RW  = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [GW-1:0] exp_q[$];
  logic [GW-1:0] exp_v;

  mem_stage_if #(.GPR_WIDTH(GW), .PC_WIDTH(PW), .GRP_ADDR_WIDTH(RW)) bus ();

`ifdef LAPIDO_MEM_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_branches_taken;
`endif

  mem_stage #(.DMEM_ADDR_BITS(AB), .GPR_WIDTH(GW), .PC_WIDTH(PW), .GRP_ADDR_WIDTH(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef LAPIDO_MEM_STATS_EN
    ,
    .stat_loads          (stat_loads),
    .stat_stores         (stat_stores),
    .stat_branches_taken (stat_branches_taken)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive_idle();
    bus.mem_write_enable = 1'b0;
    bus.sel_beq_bne      = 1'b0;
    bus.sel_jt_jf        = 1'b0;
    bus.is_branch        = 1'b0;
    bus.sel_jflag_branch = 1'b0;
    bus.cond_sel         = 3'd0;
    bus.wb_res_mux       = 2'b00;
    bus.reg_write_enable = 1'b0;
    bus.imm              = '0;
    bus.next_pc          = '0;
    bus.branch_addr      = '0;
    bus.alu_res          = '0;
    bus.mem_addr         = '0;
    bus.mem_data         = '0;
    bus.flags            = '0;
    bus.reg_dest         = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [GW-1:0] addr, input logic [GW-1:0] data);
    drive_idle();
    bus.mem_write_enable = 1'b1;
    bus.mem_addr         = addr;
    bus.mem_data         = data;
  endtask

  task automatic drive_load(input logic [GW-1:0] addr, input logic [RW-1:0] rd);
    drive_idle();
    bus.wb_res_mux       = 2'b01;
    bus.reg_write_enable = 1'b1;
    bus.mem_addr         = addr;
    bus.reg_dest         = rd;
  endtask

  task automatic drive_random();
    bus.sel_beq_bne      = 1'($urandom_range(0, 1));
    bus.sel_jt_jf        = 1'($urandom_range(0, 1));
    bus.is_branch        = 1'b1;
    bus.sel_jflag_branch = 1'($urandom_range(0, 1));
    bus.cond_sel         = 3'($urandom_range(0, 7));
    bus.wb_res_mux       = 2'($urandom_range(0, 3));
    bus.reg_write_enable = 1'b1;
    bus.imm              = GW'($urandom());
    bus.next_pc          = PW'($urandom());
    bus.branch_addr      = PW'($urandom());
    bus.alu_res          = GW'($urandom());
    bus.mem_write_enable = 1'b1;
    bus.mem_addr         = 32'd9;
    bus.mem_data         = GW'($urandom());
    bus.flags            = 6'b111111;
    bus.reg_dest         = RW'($urandom_range(1, 15));
  endtask

  // scoreboard compare
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive_idle();
    step();
    rst = 1'b0;

    // seed a word that a reset with pending stores must not disturb
    drive_store(32'd9, 32'h1234_5678);
    step();

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_random();
      #1;
      check_eq("rst_branch_taken", 64'(bus.branch_taken), 64'd0);
      step();
    end
    check_eq("rst_mem_wb_data", 64'(bus.MEM_WB_data), 64'd0);
    check_eq("rst_reg_dest", 64'(bus.out_reg_dest), 64'd0);
    check_eq("rst_reg_we", 64'(bus.out_reg_write_enable), 64'd0);
    rst = 1'b0;
    drive_load(32'd9, 4'd1);
    step();
    check_eq("rst_mem_kept", 64'(bus.MEM_WB_data), 64'h1234_5678);

    // store then load back, including an aliased address
    drive_store(32'd5, 32'hDEAD_BEEF);
    step();
    drive_load(32'd5, 4'd3);
    step();
    check_eq("load_data", 64'(bus.MEM_WB_data), 64'hDEAD_BEEF);
    check_eq("load_reg_dest", 64'(bus.out_reg_dest), 64'd3);
    check_eq("load_reg_we", 64'(bus.out_reg_write_enable), 64'd1);
    drive_load(32'd5 + 32'd1024, 4'd4);
    step();
    check_eq("load_wrap", 64'(bus.MEM_WB_data), 64'hDEAD_BEEF);

    // beq/bne compare path
    drive_idle();
    bus.is_branch   = 1'b1;
    bus.branch_addr = 16'h0040;
    bus.flags       = 6'b000001;
    #1;
    check_eq("beq_taken", 64'(bus.branch_taken), 64'd1);
    check_eq("beq_target", 64'(bus.out_branch_addr), 64'h40);
    bus.sel_beq_bne = 1'b1;
    #1;
    check_eq("bne_not_taken", 64'(bus.branch_taken), 64'd0);
    bus.sel_beq_bne = 1'b0;
    bus.is_branch   = 1'b0;
    #1;
    check_eq("no_branch", 64'(bus.branch_taken), 64'd0);

    // jt/jf flag path
    bus.is_branch        = 1'b1;
    bus.sel_jflag_branch = 1'b1;
    bus.flags            = 6'b000100;
    bus.cond_sel = 3'd2; bus.sel_jt_jf = 1'b0; #1;
    check_eq("jt_c2", 64'(bus.branch_taken), 64'd1);
    bus.sel_jt_jf = 1'b1; #1;
    check_eq("jf_c2", 64'(bus.branch_taken), 64'd0);
    bus.cond_sel = 3'd7; bus.sel_jt_jf = 1'b0; #1;
    check_eq("jt_c7", 64'(bus.branch_taken), 64'd0);
    bus.sel_jt_jf = 1'b1; #1;
    check_eq("jf_c7", 64'(bus.branch_taken), 64'd1);
    bus.cond_sel = 3'd5; bus.sel_jt_jf = 1'b0; bus.flags = 6'b100000; #1;
    check_eq("jt_c5", 64'(bus.branch_taken), 64'd1);

    // write-back mux and forwarding
    for (int s = 0; s < 4; s++) begin
      drive_idle();
      bus.alu_res          = 32'd1;
      bus.imm              = 32'd2;
      bus.next_pc          = 16'd3;
      bus.mem_addr         = 32'd5;
      bus.reg_write_enable = 1'b1;
      bus.reg_dest         = RW'(s + 6);
      bus.wb_res_mux       = 2'(s);
      case (s)
        0: begin exp_q.push_back(32'd1); exp_v = 32'd1; end
        1: begin exp_q.push_back(32'hDEAD_BEEF); exp_v = 32'd1; end
        2: begin exp_q.push_back(32'd2); exp_v = 32'd2; end
        default: begin exp_q.push_back(32'd3); exp_v = 32'd3; end
      endcase
      #1;
      check_eq($sformatf("fwd_sel%0d", s), 64'(bus.EX_MEM_data), 64'(exp_v));
      step();
      check_eq($sformatf("wb_sel%0d", s), 64'(bus.MEM_WB_data), 64'(exp_q.pop_front()));
      check_eq($sformatf("wb_rd%0d", s), 64'(bus.out_reg_dest), 64'(s + 6));
    end

    // branch and store in the same cycle both take effect, and branch writes back
    drive_store(32'd7, 32'h0000_A5A5);
    bus.is_branch        = 1'b1;
    bus.flags            = 6'b000001;
    bus.reg_write_enable = 1'b1;
    bus.wb_res_mux       = 2'b11;
    bus.next_pc          = 16'h0077;
    bus.reg_dest         = 4'd15;
    #1;
    check_eq("br_st_taken", 64'(bus.branch_taken), 64'd1);
    step();
    check_eq("br_wb_data", 64'(bus.MEM_WB_data), 64'h77);
    check_eq("br_wb_we", 64'(bus.out_reg_write_enable), 64'd1);
    drive_load(32'd7, 4'd2);
    step();
    check_eq("br_st_mem", 64'(bus.MEM_WB_data), 64'hA5A5);

    // a store under reset is dropped
    rst = 1'b1;
    drive_store(32'd5, 32'h1111_1111);
    step();
    rst = 1'b0;
    drive_load(32'd5, 4'd3);
    step();
    check_eq("rst_drop_store", 64'(bus.MEM_WB_data), 64'hDEAD_BEEF);

`ifdef LAPIDO_MEM_STATS_EN
    rst = 1'b1; drive_idle(); step(); rst = 1'b0;
    drive_store(32'd20, 32'd1); step();
    rst = 1'b1; drive_idle(); step(); rst = 1'b0;
    drive_store(32'd21, 32'd2); step();
    drive_store(32'd22, 32'd3); step();
    drive_load(32'd20, 4'd1); step();
    drive_load(32'd21, 4'd2); step();
    drive_idle();
    bus.is_branch = 1'b1;
    bus.flags     = 6'b000001;
    step();
    drive_idle(); step();
    check_eq("stat_stores", 64'(stat_stores), 64'd2);
    check_eq("stat_loads", 64'(stat_loads), 64'd2);
    check_eq("stat_branches", 64'(stat_branches_taken), 64'd1);
`endif

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
